pc_attack_ctrl: RTL and testbench
=================================

PC_ATTACK_CTRL -- requirements
Module: pc_attack_ctrl

Interface
REQ-001 SHALL have parameter GRID_N, default 5, board edge length in cells (2..8).
REQ-002 SHALL have parameter MAX_TRIES, default 16, random picks before falling back to linear scan.
REQ-003 SHALL have parameter LFSR_SEED, default 8'hA5, LFSR reset value; nonzero required.
REQ-004 SHALL have port clk, input, 1, system clock; one clock only.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port pc_turn_State, input, 1, level; high while the game FSM is in PC_TURN.
REQ-007 SHALL have port load_cells, input, 1, one-cycle pulse that loads cells_init.
REQ-008 SHALL have port cells_init, input, 5, total player ship cells.
REQ-009 SHALL have port mem_addr, output, 6, player-board cell address (row*GRID_N+col).
REQ-010 SHALL have port mem_rd_en, output, 1, board read strobe.
REQ-011 SHALL have port mem_rd_data, input, 2, cell state valid the cycle after mem_rd_en.
REQ-012 SHALL have port mem_wr_en, output, 1, board write strobe.
REQ-013 SHALL have port mem_wr_data, output, 2, cell state to write.
REQ-014 SHALL have port pc_move, output, 1, one-cycle pulse when the PC turn is complete.
REQ-015 SHALL have port hit, output, 1, registered; 1 = last attack hit, 0 = missed.
REQ-016 SHALL have port no_target, output, 1, sticky; board has no attackable cell.
REQ-017 SHALL have port player_cells_left, output, 5, remaining unhit player ship cells.

Function
REQ-018 SHALL update all registers on the falling edge of clk, matching the game FSM.
REQ-019 SHALL encode cell states as EMPTY=00, SHIP=01, HIT=10, MISS=11.
REQ-020 SHALL run an 8-bit Fibonacci LFSR (taps 8,6,5,4) that advances every cycle, whatever the state.
REQ-021 SHALL implement states IDLE, PICK, READ, EVAL, WRITE, DONE.
REQ-022 IDLE: SHALL go to PICK on the cycle after a rising edge of pc_turn_State and clear the try counter.
REQ-023 PICK, random mode: row=lfsr[2:0], col=lfsr[5:3]; if row>=GRID_N or col>=GRID_N, SHALL stay in PICK and not count a try; otherwise SHALL latch the address and go to READ.
REQ-024 PICK, scan mode (tries>=MAX_TRIES): the address SHALL be the previous address +1, wrapping from GRID_N*GRID_N-1 to 0.
REQ-025 READ: SHALL assert mem_rd_en for exactly one cycle, then go to EVAL.
REQ-026 EVAL, data SHIP: SHALL set mem_wr_data=HIT and hit=1, then go to WRITE.
REQ-027 EVAL, data EMPTY: SHALL set mem_wr_data=MISS and hit=0, then go to WRITE.
REQ-028 EVAL, data HIT or MISS: SHALL increment tries (saturating) and return to PICK.
REQ-029 SHALL enter DONE with no_target=1 and no write once GRID_N*GRID_N consecutive scan-mode reads are all HIT/MISS.
REQ-030 WRITE: SHALL assert mem_wr_en for exactly one cycle at the latched address; on a hit SHALL decrement player_cells_left, saturating at 0.
REQ-031 DONE: SHALL pulse pc_move for one cycle, then go to IDLE.
REQ-032 If pc_turn_State falls in PICK, READ or EVAL, SHALL abort to IDLE with no write and no pc_move; WRITE and DONE SHALL complete.
REQ-033 load_cells SHALL take priority over a same-cycle decrement.
REQ-034 mem_rd_en and mem_wr_en SHALL never be high in the same cycle.

Reset
REQ-035 While rst is low: state=IDLE, lfsr=LFSR_SEED, tries=0, mem_addr=0, all strobes=0, mem_wr_data=EMPTY, pc_move=0, hit=0, no_target=0, player_cells_left=0.

Structure
REQ-036 Cell-state enum, state enum and LFSR tap constant SHALL live in shared package battleship_pkg.
REQ-037 The LFSR SHALL be sub-module lfsr8 (ports clk, rst, seed, q).

Verification
REQ-038 Board all SHIP except (0,0), cells_init=9, raise pc_turn_State -> one read, one write of HIT, hit=1, player_cells_left=8, pc_move pulses once.
REQ-039 Board all EMPTY -> MISS written at the picked cell, hit=0, player_cells_left unchanged.
REQ-040 Board all MISS except cell 24=SHIP -> after 16 retries scan mode wraps and hits 24; pc_move pulses once.
REQ-041 Board all HIT/MISS -> no_target=1, no mem_wr_en, pc_move pulses.
REQ-042 Drop pc_turn_State during READ -> IDLE next cycle, no write, no pc_move.
REQ-043 Assert rst during WRITE -> all outputs at reset values immediately; lfsr returns to 8'hA5.

Source files
------------

// File: rtl/battleship_pkg.sv
// Shared encodings for the battleship game blocks: board cell states,
// the PC attack FSM states, and the LFSR feedback taps.
package battleship_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_SHIP  = 2'b01,
    CELL_HIT   = 2'b10,
    CELL_MISS  = 2'b11
  } cell_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PICK,
    S_READ,
    S_EVAL,
    S_WRITE,
    S_DONE
  } state_t;

  // Polynomial x^8 + x^6 + x^5 + x^4, expressed as bit positions 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, free-running on the falling edge like the rest of the
// game logic; reloads its seed while reset is held.
module lfsr8
  import battleship_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and simulation matches the synthesized flops.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      q <= seed;
    end else begin
      q <= {q[6:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/pc_attack_ctrl.sv
// PC attack controller: picks a player cell (random, then linear scan once
// random picks keep landing on used cells), reads it, and marks HIT or MISS.
module pc_attack_ctrl
  import battleship_pkg::*;
#(
  parameter int         GRID_N    = 5,
  parameter int         MAX_TRIES = 16,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pc_turn_State,
  input  logic       load_cells,
  input  logic [4:0] cells_init,
  output logic [5:0] mem_addr,
  output logic       mem_rd_en,
  input  logic [1:0] mem_rd_data,
  output logic       mem_wr_en,
  output logic [1:0] mem_wr_data,
  output logic       pc_move,
  output logic       hit,
  output logic       no_target,
  output logic [4:0] player_cells_left
);

  localparam int                CELLS     = GRID_N * GRID_N;
  localparam int                TRY_W     = $clog2(MAX_TRIES + 1);
  localparam int                SCAN_W    = $clog2(CELLS + 1);
  localparam logic [3:0]        GRID_L    = 4'(GRID_N);
  localparam logic [5:0]        GRID_A    = 6'(GRID_N);
  localparam logic [5:0]        LAST_ADDR = 6'(CELLS - 1);
  localparam logic [TRY_W-1:0]  TRY_MAX   = TRY_W'(MAX_TRIES);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(CELLS - 1);

  state_t              state, state_next;
  logic [7:0]          lfsr_q;
  logic                lfsr_unused;
  logic                turn_d;
  logic [TRY_W-1:0]    tries, tries_next;
  logic [SCAN_W-1:0]   scan_cnt, scan_next;
  logic [5:0]          addr_next;
  cell_t               wr_data_q, wr_data_next;
  logic                hit_next, no_target_next;

  logic [2:0]          row, col;
  logic                pick_valid, scan_mode, turn_rise;
  logic [5:0]          pick_addr;

  lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

  assign lfsr_unused = ^lfsr_q[7:6];
  assign row         = lfsr_q[2:0];
  assign col         = lfsr_q[5:3];
  assign pick_valid  = ({1'b0, row} < GRID_L) && ({1'b0, col} < GRID_L);
  assign pick_addr   = {3'b000, row} * GRID_A + {3'b000, col};
  assign scan_mode   = (tries >= TRY_MAX);
  assign turn_rise   = pc_turn_State & ~turn_d;

  // Strobes decode straight from the state, so they are mutually exclusive
  // and drop the instant reset is asserted.
  assign mem_rd_en   = (state == S_READ);
  assign mem_wr_en   = (state == S_WRITE);
  assign pc_move     = (state == S_DONE);
  assign mem_wr_data = wr_data_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_next     = state;
    tries_next     = tries;
    scan_next      = scan_cnt;
    addr_next      = mem_addr;
    wr_data_next   = wr_data_q;
    hit_next       = hit;
    no_target_next = no_target;

    unique case (state)
      S_IDLE: begin
        if (turn_rise) begin
          state_next = S_PICK;
          tries_next = '0;
          scan_next  = '0;
        end
      end
      S_PICK: begin
        if (!pc_turn_State) begin
          state_next = S_IDLE;
        end else if (scan_mode) begin
          addr_next  = (mem_addr == LAST_ADDR) ? 6'd0 : mem_addr + 6'd1;
          state_next = S_READ;
        end else if (pick_valid) begin
          addr_next  = pick_addr;
          state_next = S_READ;
        end
      end
      S_READ: begin
        state_next = pc_turn_State ? S_EVAL : S_IDLE;
      end
      S_EVAL: begin
        if (!pc_turn_State) begin
          state_next = S_IDLE;
        end else begin
          case (cell_t'(mem_rd_data))
            CELL_SHIP: begin
              wr_data_next = CELL_HIT;
              hit_next     = 1'b1;
              state_next   = S_WRITE;
            end
            CELL_EMPTY: begin
              wr_data_next = CELL_MISS;
              hit_next     = 1'b0;
              state_next   = S_WRITE;
            end
            default: begin
              state_next = S_PICK;
              if (!scan_mode) begin
                tries_next = tries + TRY_W'(1);
              end else begin
                scan_next = scan_cnt + SCAN_W'(1);
                // A full lap of used cells means nothing is left to attack.
                if (scan_cnt == SCAN_LAST) begin
                  no_target_next = 1'b1;
                  state_next     = S_DONE;
                end
              end
            end
          endcase
        end
      end
      S_WRITE: state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      turn_d    <= 1'b0;
      tries     <= '0;
      scan_cnt  <= '0;
      mem_addr  <= '0;
      wr_data_q <= CELL_EMPTY;
      hit       <= 1'b0;
      no_target <= 1'b0;
    end else begin
      state     <= state_next;
      turn_d    <= pc_turn_State;
      tries     <= tries_next;
      scan_cnt  <= scan_next;
      mem_addr  <= addr_next;
      wr_data_q <= wr_data_next;
      hit       <= hit_next;
      no_target <= no_target_next;
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      player_cells_left <= '0;
    end else if (load_cells) begin
      player_cells_left <= cells_init;
    end else if (state == S_WRITE && hit && player_cells_left != 5'd0) begin
      player_cells_left <= player_cells_left - 5'd1;
    end
  end

endmodule

// File: tb/tb_pc_attack_ctrl.sv
// Directed bench for pc_attack_ctrl with a behavioural player-board memory.
module tb_pc_attack_ctrl;

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] SHIP  = 2'b01;
  localparam logic [1:0] HIT   = 2'b10;
  localparam logic [1:0] MISS  = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pc_turn = 1'b0;
  logic       load_cells = 1'b0;
  logic [4:0] cells_init = '0;
  logic [5:0] mem_addr;
  logic       mem_rd_en;
  logic [1:0] mem_rd_data = '0;
  logic       mem_wr_en;
  logic [1:0] mem_wr_data;
  logic       pc_move;
  logic       hit;
  logic       no_target;
  logic [4:0] player_cells_left;

  pc_attack_ctrl #(
    .GRID_N    (5),
    .MAX_TRIES (16),
    .LFSR_SEED (8'hA5)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .pc_turn_State     (pc_turn),
    .load_cells        (load_cells),
    .cells_init        (cells_init),
    .mem_addr          (mem_addr),
    .mem_rd_en         (mem_rd_en),
    .mem_rd_data       (mem_rd_data),
    .mem_wr_en         (mem_wr_en),
    .mem_wr_data       (mem_wr_data),
    .pc_move           (pc_move),
    .hit               (hit),
    .no_target         (no_target),
    .player_cells_left (player_cells_left)
  );

  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [1:0] board [0:63];
  int         rd_log[$];
  int         wr_cnt, mv_cnt, both_cnt, wr_addr;
  logic [1:0] wr_val;
  logic       rd_now, wr_now;
  int         exp_left;
  int         pred;
  logic       ok;

  // Reference LFSR: x^8+x^6+x^5+x^4, reset value A5, steps on every falling edge.
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  logic [7:0] m_lfsr;
  always @(negedge clk or negedge rst)
    if (!rst) m_lfsr <= 8'hA5;
    else      m_lfsr <= lfsr_step(m_lfsr);

  function automatic int first_pick(input logic [7:0] v);
    logic [7:0] s;
    s = v;
    for (int i = 0; i < 256; i++) begin
      if (s[2:0] < 3'd5 && s[5:3] < 3'd5) return int'(s[2:0]) * 5 + int'(s[5:3]);
      s = lfsr_step(s);
    end
    return -1;
  endfunction

  function automatic int first_rd();
    return (rd_log.size() > 0) ? rd_log[0] : -1;
  endfunction

  function automatic int last_rd();
    return (rd_log.size() > 0) ? rd_log[rd_log.size()-1] : -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: sample on the rising edge (DUT moves on the falling edge) and
  // act as the board memory.
  task automatic tick();
    @(posedge clk);
    rd_now = mem_rd_en;
    wr_now = mem_wr_en;
    if (mem_rd_en) begin
      mem_rd_data = board[mem_addr];
      rd_log.push_back(int'(mem_addr));
    end
    if (mem_wr_en) begin
      board[mem_addr] = mem_wr_data;
      wr_addr = int'(mem_addr);
      wr_val  = mem_wr_data;
      wr_cnt++;
    end
    if (pc_move) mv_cnt++;
    if (mem_rd_en && mem_wr_en) both_cnt++;
  endtask

  task automatic fill_board(input logic [1:0] v);
    for (int i = 0; i < 64; i++) board[i] = v;
  endtask

  task automatic clear_log();
    rd_log.delete();
    wr_cnt = 0; mv_cnt = 0; both_cnt = 0; wr_addr = -1; wr_val = '0;
  endtask

  task automatic run_turn(input string tag, output int p);
    clear_log();
    pc_turn = 1'b1;
    tick();
    p = first_pick(m_lfsr);
    for (int i = 0; i < 2000 && mv_cnt == 0; i++) tick();
    check({tag, "_finished"}, mv_cnt != 0, 1);
    pc_turn = 1'b0;
    repeat (3) tick();
  endtask

  task automatic wait_strobe(input string tag, input logic want_wr);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      tick();
      seen = want_wr ? wr_now : rd_now;
    end
    check({tag, "_strobe_seen"}, seen, 1);
  endtask

  task automatic check_scan(input string tag);
    for (int i = 16; i < rd_log.size(); i++)
      check($sformatf("%s_scan%0d", tag, i), rd_log[i], (rd_log[i-1] + 1) % 25);
  endtask

  initial begin
    fill_board(EMPTY);
    clear_log();
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    check("rst_addr",    mem_addr, 0);
    check("rst_rd_en",   mem_rd_en, 0);
    check("rst_wr_en",   mem_wr_en, 0);
    check("rst_wr_data", mem_wr_data, EMPTY);
    check("rst_pc_move", pc_move, 0);
    check("rst_hit",     hit, 0);
    check("rst_no_tgt",  no_target, 0);
    check("rst_left",    player_cells_left, 0);
    rst = 1'b1;
    tick();

    load_cells = 1'b1; cells_init = 5'd9;
    tick();
    load_cells = 1'b0;
    tick();
    check("load_left", player_cells_left, 9);
    exp_left = 9;

    // Ship everywhere except (0,0).
    fill_board(SHIP); board[0] = EMPTY;
    run_turn("ships", pred);
    check("ships_reads",   rd_log.size(), 1);
    check("ships_rd_addr", first_rd(), pred);
    check("ships_writes",  wr_cnt, 1);
    check("ships_wr_addr", wr_addr, pred);
    check("ships_wr_data", wr_val, (pred == 0) ? MISS : HIT);
    check("ships_hit",     hit, (pred == 0) ? 0 : 1);
    exp_left = (pred == 0) ? 9 : 8;
    check("ships_left",    player_cells_left, exp_left);
    check("ships_moves",   mv_cnt, 1);
    check("ships_overlap", both_cnt, 0);

    // All empty: a miss at the picked cell.
    fill_board(EMPTY);
    run_turn("empty", pred);
    check("empty_reads",   rd_log.size(), 1);
    check("empty_wr_addr", wr_addr, pred);
    check("empty_wr_data", wr_val, MISS);
    check("empty_hit",     hit, 0);
    check("empty_left",    player_cells_left, exp_left);
    check("empty_moves",   mv_cnt, 1);

    // Only cell 24 left: random picks miss until scan mode reaches it.
    fill_board(MISS); board[24] = SHIP;
    run_turn("last", pred);
    check("last_rd_first", first_rd(), pred);
    check("last_rd_bound", rd_log.size() <= 41, 1);
    check("last_rd_final", last_rd(), 24);
    check("last_writes",   wr_cnt, 1);
    check("last_wr_addr",  wr_addr, 24);
    check("last_wr_data",  wr_val, HIT);
    check("last_hit",      hit, 1);
    exp_left = exp_left - 1;
    check("last_left",     player_cells_left, exp_left);
    check("last_moves",    mv_cnt, 1);
    check_scan("last");

    // Turn dropped while the read strobe is up: abort, nothing written.
    fill_board(SHIP);
    clear_log();
    pc_turn = 1'b1;
    wait_strobe("abort", 1'b0);
    pc_turn = 1'b0;
    tick();
    check("abort_rd_off", mem_rd_en, 0);
    repeat (10) tick();
    check("abort_reads",  rd_log.size(), 1);
    check("abort_writes", wr_cnt, 0);
    check("abort_moves",  mv_cnt, 0);
    check("abort_left",   player_cells_left, exp_left);

    // load_cells in the write cycle wins over the hit decrement.
    clear_log();
    pc_turn = 1'b1;
    wait_strobe("prio", 1'b1);
    load_cells = 1'b1; cells_init = 5'd20;
    tick();
    load_cells = 1'b0;
    for (int i = 0; i < 50 && mv_cnt == 0; i++) tick();
    pc_turn = 1'b0;
    repeat (3) tick();
    exp_left = 20;
    check("prio_left",   player_cells_left, exp_left);
    check("prio_writes", wr_cnt, 1);
    check("prio_moves",  mv_cnt, 1);

    // Nothing attackable: 16 random reads then one full scan lap.
    for (int i = 0; i < 64; i++) board[i] = (i % 2 == 1) ? MISS : HIT;
    run_turn("full", pred);
    check("full_reads",   rd_log.size(), 41);
    check("full_rd_first", first_rd(), pred);
    check("full_writes",  wr_cnt, 0);
    check("full_no_tgt",  no_target, 1);
    check("full_moves",   mv_cnt, 1);
    check("full_overlap", both_cnt, 0);
    check("full_left",    player_cells_left, exp_left);
    check_scan("full");

    // Reset in the middle of a write.
    fill_board(SHIP);
    clear_log();
    pc_turn = 1'b1;
    wait_strobe("midrst", 1'b1);
    #1 rst = 1'b0;
    #1;
    check("midrst_addr",    mem_addr, 0);
    check("midrst_rd_en",   mem_rd_en, 0);
    check("midrst_wr_en",   mem_wr_en, 0);
    check("midrst_wr_data", mem_wr_data, EMPTY);
    check("midrst_pc_move", pc_move, 0);
    check("midrst_hit",     hit, 0);
    check("midrst_no_tgt",  no_target, 0);
    check("midrst_left",    player_cells_left, 0);
    pc_turn = 1'b0;
    @(posedge clk);
    rst = 1'b1;
    repeat (2) tick();

    // After reset the LFSR restarts from A5; a hit at zero cells stays at zero.
    fill_board(SHIP); board[0] = EMPTY;
    run_turn("post", pred);
    check("post_wr_addr", wr_addr, pred);
    check("post_wr_data", wr_val, (pred == 0) ? MISS : HIT);
    check("post_left",    player_cells_left, 0);
    check("post_moves",   mv_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no end of test, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
